sprite_line_scheduler: RTL and testbench

- Per-scanline sprite scheduler for the 640x480 video pipeline. Runs during horizontal blanking.
- Scans the sprite Y table against the next line to be drawn. Selects up to SLOTS hit sprites in index order.
- Fetches each selected sprite's 16-bit row bitmap through one shared sprite-ROM request/ack port.
- Commits the results to double-buffered slot outputs read by the pixel mixer during the next visible line.

---
 rtl/sprite_line_scheduler.sv | 150 +++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the sprite Y table during horizontal blank,
// fetches up to SLOTS row bitmaps from the sprite ROM and commits them for the next line.
module sprite_line_scheduler #(
    parameter int NUM_SPR = 8,
    parameter int ID_W    = 3,
    parameter int SLOTS   = 4,
    parameter int ROW_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_start,
    input  logic [8:0]              next_y,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [9*NUM_SPR-1:0]    spr_y,
    output logic                    rom_req,
    output logic [ID_W+ROW_W-1:0]   rom_addr,
    input  logic                    rom_ack,
    input  logic [15:0]             rom_data,
    output logic [SLOTS-1:0]        slot_valid,
    output logic [ID_W*SLOTS-1:0]   slot_id,
    output logic [16*SLOTS-1:0]     slot_row,
    output logic                    overflow,
    output logic                    done,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_SPR - 1);
    localparam logic [CNT_W-1:0] SLOTS_C  = CNT_W'(SLOTS);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

    state_t            state, state_nxt;
    logic [8:0]        line_y;
    logic [ID_W-1:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic [SLOTS-1:0]  sh_valid;
    logic [ID_W-1:0]   sh_id  [SLOTS];
    logic [15:0]       sh_row [SLOTS];

    logic [8:0]        cur_y;
    logic [9:0]        diff;
    logic              hit;
    logic              slot_free;
    logic              last;

    // Negative differences set bit 9, so one zero test on the upper bits covers both bounds
    assign cur_y     = spr_y[9*int'(idx) +: 9];
    assign diff      = {1'b0, line_y} - {1'b0, cur_y};
    assign hit       = spr_en[idx] && (diff[9:ROW_W] == '0);
    assign slot_free = (cnt < SLOTS_C);
    assign last      = (idx == LAST_IDX);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (line_start) state_nxt = SCAN;
            SCAN: begin
                if (hit && slot_free) state_nxt = FETCH;
                else if (last)        state_nxt = DONE;
            end
            FETCH: if (rom_ack) state_nxt = last ? DONE : SCAN;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_y     <= '0;
            idx        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            slot_valid <= '0;
            slot_id    <= '0;
            slot_row   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            sh_valid   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                sh_id[i]  <= '0;
                sh_row[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            overrun <= line_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (line_start) begin
                        line_y   <= next_y;
                        idx      <= '0;
                        cnt      <= '0;
                        ovf      <= 1'b0;
                        sh_valid <= '0;
                        for (int i = 0; i < SLOTS; i++) begin
                            sh_id[i]  <= '0;
                            sh_row[i] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (hit && slot_free) begin
                        rom_req  <= 1'b1;
                        rom_addr <= {idx, diff[ROW_W-1:0]};
                    end else begin
                        if (hit) ovf <= 1'b1;
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_ack) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                sh_valid[i] <= 1'b1;
                                sh_id[i]    <= idx;
                                sh_row[i]   <= rom_data;
                            end
                        end
                        cnt     <= cnt + 1'b1;
                        rom_req <= 1'b0;
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    slot_valid <= sh_valid;
                    for (int i = 0; i < SLOTS; i++) begin
                        slot_id[ID_W*i +: ID_W] <= sh_id[i];
                        slot_row[16*i +: 16]    <= sh_row[i];
                    end
                    overflow <= ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a latency-programmable sprite ROM responder.
module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [8:0]  next_y;
    logic [7:0]  spr_en;
    logic [71:0] spr_y;
    logic        rom_req;
    logic [6:0]  rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = 16'h0;
    logic [3:0]  slot_valid;
    logic [11:0] slot_id;
    logic [63:0] slot_row;
    logic        overflow, done, overrun, busy;

    int total = 0;
    int bad   = 0;

    int   ack_lat   = 2;
    bit   ack_en    = 1'b1;
    bit   force_ack = 1'b0;
    int   wait_cnt  = 0;
    logic [6:0] addr_log [64];
    int   n_log      = 0;
    int   req_cycles = 0;

    sprite_line_scheduler dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_y(next_y),
        .spr_en(spr_en), .spr_y(spr_y), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data), .slot_valid(slot_valid),
        .slot_id(slot_id), .slot_row(slot_row), .overflow(overflow), .done(done),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [6:0] a);
        return {a, 2'b10, ~a};
    endfunction

    // ROM model: answers a held request ack_lat cycles after it rises, logging each address
    always begin
        @(negedge clk);
        #1;
        rom_ack = 1'b0;
        if (force_ack) begin
            rom_ack  = 1'b1;
            rom_data = 16'hBEEF;
        end else if (rom_req && ack_en) begin
            wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                rom_ack  = 1'b1;
                rom_data = rom_word(rom_addr);
                if (n_log < 64) addr_log[n_log] = rom_addr;
                n_log++;
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
        if (rom_req) req_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] y);
        next_y     = y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic set_y(input int i, input logic [8:0] y);
        spr_y[9*i +: 9] = y;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 1;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!rom_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", 64'(rom_req), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, base, r0, unstable;

        rst = 1'b1; line_start = 1'b0; next_y = '0; spr_en = '0; spr_y = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rom_req",  64'(rom_req),    64'd0);
        checkOutput("rst_rom_addr", 64'(rom_addr),   64'd0);
        checkOutput("rst_valid",    64'(slot_valid), 64'd0);
        checkOutput("rst_id",       64'(slot_id),    64'd0);
        checkOutput("rst_row",      slot_row,        64'd0);
        checkOutput("rst_flags",    64'({overflow, done, overrun, busy}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] empty table");
        r0 = req_cycles;
        applyStimulus(9'd10);
        wait_done(40, cyc);
        checkOutput("empty_latency", 64'(cyc), 64'd10);
        checkOutput("empty_valid", 64'(slot_valid), 64'd0);
        checkOutput("empty_ovf", 64'(overflow), 64'd0);
        checkOutput("empty_noreq", 64'(req_cycles - r0), 64'd0);
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd0);

        $display("[TB] three hits, latency 2");
        spr_en = 8'b1010_0100;
        set_y(2, 9'd90); set_y(5, 9'd100); set_y(7, 9'd85);
        base = n_log;
        applyStimulus(9'd100);
        wait_done(60, cyc);
        checkOutput("hits_latency", 64'(cyc), 64'd16);
        checkOutput("hits_nfetch", 64'(n_log - base), 64'd3);
        checkOutput("hits_addr0", 64'(addr_log[base]),     64'd42);
        checkOutput("hits_addr1", 64'(addr_log[base + 1]), 64'd80);
        checkOutput("hits_addr2", 64'(addr_log[base + 2]), 64'd127);
        checkOutput("hits_valid", 64'(slot_valid), 64'b0111);
        checkOutput("hits_id", 64'(slot_id), 64'({3'd0, 3'd7, 3'd5, 3'd2}));
        checkOutput("hits_row", slot_row, {16'h0, rom_word(7'd127), rom_word(7'd80), rom_word(7'd42)});
        checkOutput("hits_ovf", 64'(overflow), 64'd0);

        $display("[TB] row boundaries");
        spr_y = '0;
        spr_en = 8'b0000_0111;
        set_y(0, 9'd100); set_y(1, 9'd101); set_y(2, 9'd120); set_y(3, 9'd116);
        base = n_log;
        applyStimulus(9'd116);
        wait_done(60, cyc);
        checkOutput("bnd_nfetch", 64'(n_log - base), 64'd1);
        checkOutput("bnd_addr", 64'(addr_log[base]), 64'd31);
        checkOutput("bnd_valid", 64'(slot_valid), 64'b0001);
        checkOutput("bnd_id", 64'(slot_id), 64'd1);
        checkOutput("bnd_row", slot_row, {48'h0, rom_word(7'd31)});

        $display("[TB] no vertical wrap");
        spr_en = 8'b0100_0000;
        set_y(6, 9'd505);
        r0 = req_cycles;
        applyStimulus(9'd2);
        wait_done(40, cyc);
        checkOutput("wrap_valid", 64'(slot_valid), 64'd0);
        checkOutput("wrap_noreq", 64'(req_cycles - r0), 64'd0);

        $display("[TB] overflow");
        spr_en = 8'hFF;
        for (int i = 0; i < 8; i++) set_y(i, 9'd200);
        base = n_log;
        applyStimulus(9'd205);
        wait_done(80, cyc);
        checkOutput("ovf_nfetch", 64'(n_log - base), 64'd4);
        checkOutput("ovf_addr3", 64'(addr_log[base + 3]), 64'd53);
        checkOutput("ovf_valid", 64'(slot_valid), 64'b1111);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_id", 64'(slot_id), 64'({3'd3, 3'd2, 3'd1, 3'd0}));
        checkOutput("ovf_row", slot_row, {rom_word(7'd53), rom_word(7'd37), rom_word(7'd21), rom_word(7'd5)});

        spr_en = 8'b0100_0000;
        set_y(6, 9'd205);
        applyStimulus(9'd205);
        wait_done(40, cyc);
        checkOutput("ovf_clear", 64'(overflow), 64'd0);
        checkOutput("one_valid", 64'(slot_valid), 64'b0001);
        checkOutput("one_id", 64'(slot_id), 64'd6);

        $display("[TB] ack stall with overrun");
        ack_en = 1'b0;
        spr_en = 8'b0000_0001;
        set_y(0, 9'd50);
        applyStimulus(9'd60);
        wait_req(20);
        checkOutput("stall_addr", 64'(rom_addr), 64'd10);
        unstable = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(rom_req === 1'b1 && rom_addr === 7'd10)) unstable++;
            if (i == 50) begin
                next_y     = 9'd50;
                line_start = 1'b1;
            end
            if (i == 51) begin
                line_start = 1'b0;
                checkOutput("overrun_pulse", 64'(overrun), 64'd1);
            end
            if (i == 52) begin
                checkOutput("overrun_end", 64'(overrun), 64'd0);
                checkOutput("stall_busy", 64'(busy), 64'd1);
            end
        end
        checkOutput("stall_stable", 64'(unstable), 64'd0);
        checkOutput("stall_slots_held", 64'(slot_id), 64'd6);
        ack_en = 1'b1;
        wait_done(40, cyc);
        checkOutput("stall_valid", 64'(slot_valid), 64'b0001);
        checkOutput("stall_id", 64'(slot_id), 64'd0);
        checkOutput("stall_row", slot_row, {48'h0, rom_word(7'd10)});

        $display("[TB] reset during fetch");
        ack_en = 1'b0;
        applyStimulus(9'd60);
        wait_req(20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mrst_req", 64'(rom_req), 64'd0);
        checkOutput("mrst_busy", 64'(busy), 64'd0);
        checkOutput("mrst_valid", 64'(slot_valid), 64'd0);
        checkOutput("mrst_row", slot_row, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_busy", 64'(busy), 64'd0);
        checkOutput("stray_valid", 64'(slot_valid), 64'd0);
        checkOutput("stray_row", slot_row, 64'd0);
        checkOutput("stray_flags", 64'({rom_req, done, overflow}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
